muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and
// restoring divide, one bit per cycle, with sign fix-up in a single final cycle.
package alu_op_pkg;
    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_SUB    = 5'h01;
    localparam logic [4:0] OP_AND    = 5'h02;
    localparam logic [4:0] OP_OR     = 5'h03;
    localparam logic [4:0] OP_XOR    = 5'h04;
    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHSU = 5'h12;
    localparam logic [4:0] OP_MULHU  = 5'h13;
    localparam logic [4:0] OP_DIV    = 5'h14;
    localparam logic [4:0] OP_DIVU   = 5'h15;
    localparam logic [4:0] OP_REM    = 5'h16;
    localparam logic [4:0] OP_REMU   = 5'h17;
endpackage

module muldiv_unit
    import alu_op_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [2*XLEN-1:0]   work_q, work_d;
    logic                a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic                b_zero_q, b_zero_d, ovf_q, ovf_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                op_valid, a_signed, b_signed, a_neg_in, b_neg_in, is_div;
    logic [XLEN:0]       mul_sum, div_diff;
    logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;
    logic [XLEN-1:0]     quot, rem, fix_val;

    assign op_valid = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                 OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign a_signed = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign b_signed = op inside {OP_MULH, OP_DIV, OP_REM};
    assign a_neg_in = a_signed && a[XLEN-1];
    assign b_neg_in = b_signed && b[XLEN-1];
    assign is_div   = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    // Multiply: low half of work holds the multiplier, shifted out LSB first.
    assign mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, work_q[XLEN-1:1]};

    // Divide: {remainder, dividend/quotient} shifts left; quotient bits enter at the LSB.
    assign div_diff = work_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    assign div_next = div_diff[XLEN] ? {work_q[2*XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], work_q[XLEN-2:0], 1'b1};

    assign prod_fix = (a_neg_q ^ b_neg_q) ? -work_q : work_q;
    assign quot     = work_q[XLEN-1:0];
    assign rem      = work_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_val = '0;
        case (op_q)
            OP_MUL:                       fix_val = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (b_zero_q)               fix_val = '1;
                else if (ovf_q)             fix_val = a_q;
                else if (a_neg_q ^ b_neg_q) fix_val = -quot;
                else                        fix_val = quot;
            end
            OP_REM, OP_REMU: begin
                if (b_zero_q)     fix_val = a_q;
                else if (ovf_q)   fix_val = '0;
                else if (a_neg_q) fix_val = -rem;
                else              fix_val = rem;
            end
            default:              fix_val = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        opb_d    = opb_q;
        work_d   = work_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        b_zero_d = b_zero_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (!flush && start && op_valid) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    op_d     = op;
                    a_d      = a;
                    a_neg_d  = a_neg_in;
                    b_neg_d  = b_neg_in;
                    opb_d    = b_neg_in ? -b : b;
                    work_d   = {{XLEN{1'b0}}, (a_neg_in ? -a : a)};
                    b_zero_d = (b == '0);
                    ovf_d    = (op == OP_DIV || op == OP_REM) && (a == MIN_NEG) && (b == '1);
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    work_d = is_div ? div_next : mul_next;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_val;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            opb_q    <= '0;
            work_q   <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            opb_q    <= opb_d;
            work_q   <= work_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            b_zero_q <= b_zero_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE) && !flush;
    assign result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of ops with hand-computed
// results, plus abort / reset / ignored-start sequences.
module tb_muldiv_unit;
    import alu_op_pkg::*;

    logic        clk, rst_n, start, flush, busy, done;
    logic [4:0]  op;
    logic [31:0] a, b, result;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] last_exp = '0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[18];

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issues one op and watches busy/done for cycles 1..36 after the accept edge.
    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input bit mid_start, input string name);
        logic [31:0] res;
        int done_cyc, done_cnt;
        bit busy_bad;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        res = '0; done_cyc = -1; done_cnt = 0; busy_bad = 1'b0;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (mid_start && cyc == 5) begin
                start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd3;
            end
            if (busy !== (cyc <= 34)) busy_bad = 1'b1;
            if (done === 1'b1) begin
                done_cnt++; done_cyc = cyc; res = result;
            end
        end
        check({name, "_latency"}, 32'(done_cyc), 32'd34);
        check({name, "_done_count"}, 32'(done_cnt), 32'd1);
        check({name, "_busy_window"}, {31'd0, busy_bad}, 32'd0);
        check({name, "_result"}, res, exp);
        check({name, "_result_held"}, result, exp);
        last_exp = exp;
    endtask

    // Expects the unit idle, with no done and an unchanged result, for n cycles.
    task automatic expect_quiet(input int n, input string name);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy !== 1'b0 || done !== 1'b0 || result !== last_exp) bad = 1'b1;
        end
        check(name, {31'd0, bad}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{OP_MUL,    32'd7,        32'd6,        32'd42,       "mul_7x6"};
        vecs[1]  = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1xm1"};
        vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max"};
        vecs[3]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_m7_2"};
        vecs[4]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_m7_2"};
        vecs[5]  = '{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, "divu_by0"};
        vecs[6]  = '{OP_REMU,   32'd5,        32'd0,        32'd5,        "remu_by0"};
        vecs[7]  = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf"};
        vecs[8]  = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf"};
        vecs[9]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, "mulhsu_m1x2"};
        vecs[10] = '{OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "mulhsu_min"};
        vecs[11] = '{OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, "mul_trunc"};
        vecs[12] = '{OP_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, "mul_m3x5"};
        vecs[13] = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, "mulh_min2"};
        vecs[14] = '{OP_MULHU,  32'h80000000, 32'd2,        32'h00000001, "mulhu_carry"};
        vecs[15] = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       "divu_100_7"};
        vecs[16] = '{OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        "rem_7_m2"};
        vecs[17] = '{OP_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, "rem_m5_by0"};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = OP_ADD; a = '0; b = '0;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);

        // First accept on the very first rising edge after reset release.
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 32'd9; b = 32'd9;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("first_accept_busy", {31'd0, busy}, 32'd1);
        for (int cyc = 2; cyc <= 34; cyc++) @(negedge clk);
        check("first_accept_done", {31'd0, done}, 32'd1);
        check("first_accept_result", result, 32'd81);
        last_exp = 32'd81;

        for (int i = 0; i < 18; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, vecs[i].name);

        run_op(OP_MUL, 32'd7, 32'd6, 32'd42, 1'b1, "start_while_busy");

        // Unknown op code is ignored.
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd2;
        expect_quiet(40, "illegal_op_ignored");

        // Flush and start together in IDLE: nothing accepted.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_idle_busy", {31'd0, busy}, 32'd0);
        expect_quiet(40, "flush_start_idle_quiet");

        // Flush at cycle 10 of CALC.
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd3;
        @(posedge clk);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_cycle11_busy", {31'd0, busy}, 32'd0);
        expect_quiet(40, "flush_no_done");

        // Flush during DONE suppresses the pulse.
        @(negedge clk);
        start = 1'b1; op = OP_REMU; a = 32'd100; b = 32'd7;
        @(posedge clk);
        for (int cyc = 1; cyc <= 34; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        #1;
        check("flush_done_suppressed", {31'd0, done}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_busy", {31'd0, busy}, 32'd0);
        last_exp = result;

        // Asynchronous reset at cycle 20.
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd10;
        @(posedge clk);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_result", result, 32'd0);
        last_exp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet(40, "midreset_no_done");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end
endmodule
